mtl_frame_writer: RTL
=====================

# mtl_frame_writer

Write-side counterpart of the MTL display path. Accepts a stream of 24-bit RGB pixels from the PIC32 link, in raster order, and packs them into 32-bit words. It pushes these words, with per-frame base addresses, into the SDRAM write FIFO, filling one slideshow frame buffer per image. It drives the `oLoading` level consumed by `mtl_controller` (`iLoading`), so the display shows the loading screen until every frame is stored.

## Interface
Parameters:
- `H_ACTIVE`, 800: pixels per line.
- `V_ACTIVE`, 480: lines per frame.
- `ADDR_W`, 23: SDRAM word-address width.
- `FRAME_STRIDE`, 524288: word distance between frame bases; must be ≥ `H_ACTIVE*V_ACTIVE`.
- `NF_W`, 4: width of the frame-count input.

Ports:
- `iCLK`  in  1  clock.
- `iRST_n`  in  1  reset, asynchronous, active-low.
- `iSTART`  in  1  single-cycle pulse; starts loading of `iNUM_FRAMES` frames.
- `iNUM_FRAMES`  in  `NF_W`  number of frames; sampled on an accepted `iSTART`.
- `iABORT`  in  1  abandons loading at once.
- `iPIX_VALID`  in  1  pixel present on `iPIX_DATA`.
- `iPIX_DATA`  in  24  {R,G,B}.
- `oPIX_READY`  out  1  writer can accept a pixel this cycle.
- `oWR_ADDR_LOAD`  out  1  pulse; SDRAM write port loads `oWR_BASE`.
- `oWR_BASE`  out  `ADDR_W`  base address of the current frame.
- `oWR_EN`  out  1  write `oWR_DATA` into the SDRAM write FIFO.
- `oWR_DATA`  out  32  {8'h00, R, G, B}.
- `iWR_FULL`  in  1  SDRAM write FIFO full.
- `oLoading`  out  1  loading in progress; connects to `mtl_controller.iLoading`.
- `oFrameDone`  out  1  pulse after the last word of each frame.
- `oDone`  out  1  pulse after the last frame.
- `oFrameIdx`  out  `NF_W`  index of the frame being written.

## Operation
- State machine: `IDLE`, `START_FRAME`, `STREAM`, `FRAME_END`.
  - `IDLE`: `iSTART` && `iNUM_FRAMES`≠0 → latch the count, frame_idx←0, → `START_FRAME`. `iSTART` with `iNUM_FRAMES`=0 is ignored.
  - `START_FRAME` (1 cycle): `oWR_ADDR_LOAD`=1, `oWR_BASE`=frame_idx*`FRAME_STRIDE` (truncated to `ADDR_W`); x←0, y←0 → `STREAM`.
  - `STREAM`: `oPIX_READY` = !`iWR_FULL`. A transfer occurs when `iPIX_VALID` && `oPIX_READY`. Each transfer advances x. When x = `H_ACTIVE`-1, x wraps to 0 and y advances. The transfer at (x,y) = (`H_ACTIVE`-1, `V_ACTIVE`-1) → `FRAME_END`.
  - `FRAME_END` (1 cycle): `oFrameDone`=1. If frame_idx = count-1: `oDone`=1 → `IDLE`. Otherwise frame_idx+1 → `START_FRAME`.
- `oPIX_READY`=0 in every state except `STREAM`.
- `iSTART` outside `IDLE` is ignored.
- `iABORT` wins over every other event in any state. Next cycle: `IDLE`, `oLoading`=0, no `oFrameDone`/`oDone`. A write registered in the abort cycle still issues.
- `oLoading` = 1 in every state except `IDLE`, registered: it rises the cycle after the accepted `iSTART` and falls the cycle after `FRAME_END` or abort.
- Arithmetic: x is `$clog2(H_ACTIVE)` bits and y is `$clog2(V_ACTIVE)` bits. The base address is built by multiply with truncation; no overflow flag.

## Timing
- Reset values: all outputs 0 (`oLoading`, `oPIX_READY`, `oWR_EN`, `oWR_DATA`, `oWR_BASE`, `oWR_ADDR_LOAD`, `oFrameDone`, `oDone`, `oFrameIdx`). State is `IDLE` and the counters are 0.
- Latency: a pixel accepted in cycle n gives `oWR_EN`=1 with its data in cycle n+1. `oWR_EN` is high only in those cycles.
- `iWR_FULL` gates `oPIX_READY` combinationally in the same cycle. A word already registered still issues; the FIFO must keep 1 entry of slack when it asserts full.
- `iSTART` → `oWR_ADDR_LOAD` is 1 cycle later. With the FIFO never full, one frame takes 2 + `H_ACTIVE`*`V_ACTIVE` cycles, measured from the `START_FRAME` cycle to the `FRAME_END` cycle inclusive.
- The last data word (n+1) coincides with the `FRAME_END` cycle.
- Reset mid-frame: returns to `IDLE` immediately, asynchronously; partial frame contents are undefined.

## Structure
- Package `mtl_pkg`: `H_ACTIVE`/`V_ACTIVE` constants, `FRAME_STRIDE`, the state enum `mtl_wr_state_t`, and the pixel word packing function. Shared with `mtl_controller`'s address generation.
- One sub-module: `mtl_raster_counter`, an x/y counter with enable, clear, wrap and end-of-frame flag. Reused by the readback path.

## Test plan
- Reset, then `iSTART` with `iNUM_FRAMES`=1 and continuous valid pixels (data = index):
  - `oWR_ADDR_LOAD`=1 with `oWR_BASE`=0 one cycle after start.
  - 384000 `oWR_EN` words, with word k = k.
  - `oFrameDone` and `oDone` in the same cycle; `oLoading` falls 1 cycle later.
- `iNUM_FRAMES`=3: `oWR_BASE` takes 0, 524288, 1048576 in turn; `oFrameIdx` takes 0,1,2; exactly 3 `oFrameDone` pulses and 1 `oDone` pulse.
- `iWR_FULL` held high for 10 cycles mid-line (x=400):
  - `oPIX_READY`=0 in the same cycles.
  - No pixel lost or duplicated; the line wrap at x=799→0 stays correct.
- `iABORT` at y=100: next cycle `IDLE`, `oLoading`=0, no done pulses. A subsequent `iSTART` restarts at `oWR_BASE`=0 with x=y=0.
- Stray `iSTART` during `STREAM`, and `iSTART` with `iNUM_FRAMES`=0 while `IDLE`: both ignored; counters, `oFrameIdx` and `oLoading` unchanged.
- `iRST_n` asserted asynchronously mid-frame: all outputs 0 immediately; after release, a full 1-frame load completes normally.

Source files
------------

// File: rtl/mtl_pkg.sv
// mtl_pkg: shared definitions for the MTL display write/read paths.
//   - Default panel geometry and the word stride between frame buffers.
//   - Frame-writer state encoding.
//   - Pixel packing: 24-bit {R,G,B} into a 32-bit SDRAM word.
package mtl_pkg;

  localparam int MTL_H_ACTIVE     = 800;
  localparam int MTL_V_ACTIVE     = 480;
  localparam int MTL_FRAME_STRIDE = 524288;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    START_FRAME = 2'd1,
    STREAM      = 2'd2,
    FRAME_END   = 2'd3
  } mtl_wr_state_t;

  // The upper byte is unused padding so one pixel occupies one SDRAM word.
  function automatic logic [31:0] packPixel(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction

endpackage

// File: rtl/mtl_raster_counter.sv
// mtl_raster_counter: raster-order x/y position counter.
// Ports:
//   iCLK, iRST_n    clock, asynchronous active-low reset
//   iClear          synchronous return to (0,0); wins over iEnable
//   iEnable         advance one pixel position
//   oX, oY          current position
//   oLineEnd        x is on the last pixel of the line
//   oFrameEnd       position is the last pixel of the frame
module mtl_raster_counter
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE = MTL_H_ACTIVE,
  parameter int V_ACTIVE = MTL_V_ACTIVE,
  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic           iCLK,
  input  logic           iRST_n,
  input  logic           iClear,
  input  logic           iEnable,
  output logic [X_W-1:0] oX,
  output logic [Y_W-1:0] oY,
  output logic           oLineEnd,
  output logic           oFrameEnd
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0] xReg;
  logic [Y_W-1:0] yReg;

  assign oX        = xReg;
  assign oY        = yReg;
  assign oLineEnd  = (xReg == X_LAST);
  assign oFrameEnd = oLineEnd && (yReg == Y_LAST);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      xReg <= '0;
      yReg <= '0;
    end else if (iClear) begin
      xReg <= '0;
      yReg <= '0;
    end else if (iEnable) begin
      if (oLineEnd) begin
        xReg <= '0;
        yReg <= (yReg == Y_LAST) ? '0 : yReg + 1'b1;
      end else begin
        xReg <= xReg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mtl_frame_writer.sv
// mtl_frame_writer: packs a raster stream of 24-bit RGB pixels into 32-bit
// words and writes them into the SDRAM write FIFO, one frame buffer per image.
// Ports:
//   iCLK, iRST_n                 clock, asynchronous active-low reset
//   iSTART, iNUM_FRAMES          start pulse and frame count (0 = ignored)
//   iABORT                       abandon loading immediately
//   iPIX_VALID, iPIX_DATA        pixel stream in, oPIX_READY handshake
//   oWR_ADDR_LOAD, oWR_BASE      load pulse and base address of current frame
//   oWR_EN, oWR_DATA, iWR_FULL   write FIFO interface
//   oLoading                     high while frames are being stored
//   oFrameDone, oDone            end-of-frame / end-of-load pulses
//   oFrameIdx                    index of the frame being written
module mtl_frame_writer
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE     = MTL_H_ACTIVE,
  parameter int V_ACTIVE     = MTL_V_ACTIVE,
  parameter int ADDR_W       = 23,
  parameter int FRAME_STRIDE = MTL_FRAME_STRIDE,
  parameter int NF_W         = 4
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iSTART,
  input  logic [NF_W-1:0]   iNUM_FRAMES,
  input  logic              iABORT,
  input  logic              iPIX_VALID,
  input  logic [23:0]       iPIX_DATA,
  output logic              oPIX_READY,
  output logic              oWR_ADDR_LOAD,
  output logic [ADDR_W-1:0] oWR_BASE,
  output logic              oWR_EN,
  output logic [31:0]       oWR_DATA,
  input  logic              iWR_FULL,
  output logic              oLoading,
  output logic              oFrameDone,
  output logic              oDone,
  output logic [NF_W-1:0]   oFrameIdx
);

  localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  // Truncating the stride first gives the same result as truncating the
  // full product, since both are taken modulo 2**ADDR_W.
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(FRAME_STRIDE);

  mtl_wr_state_t   stateReg, stateNext;
  logic [NF_W-1:0] countReg, frameIdxReg;
  logic            loadingReg, wrEnReg;
  logic [31:0]     wrDataReg;
  logic            pixXfer, lastFrame, frameEnd, lineEnd;
  logic [X_W-1:0]  xPos;
  logic [Y_W-1:0]  yPos;
  logic            unusedPos;

  mtl_raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) rasterCounter (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iClear    (stateReg == START_FRAME),
    .iEnable   (pixXfer),
    .oX        (xPos),
    .oY        (yPos),
    .oLineEnd  (lineEnd),
    .oFrameEnd (frameEnd)
  );

  // Position itself is not needed here; only the end-of-frame flag is.
  assign unusedPos = ^{xPos, yPos, lineEnd};

  // Ready follows FIFO full combinationally; the FIFO keeps one entry of
  // slack for the word already registered in wrDataReg.
  assign oPIX_READY = (stateReg == STREAM) && !iWR_FULL;
  assign pixXfer    = iPIX_VALID && oPIX_READY;
  assign lastFrame  = (frameIdxReg == countReg - NF_W'(1));

  assign oWR_BASE  = ADDR_W'(frameIdxReg) * STRIDE_A;
  assign oWR_EN    = wrEnReg;
  assign oWR_DATA  = wrDataReg;
  assign oLoading  = loadingReg;
  assign oFrameIdx = frameIdxReg;

  always_comb begin
    stateNext     = stateReg;
    oWR_ADDR_LOAD = 1'b0;
    oFrameDone    = 1'b0;
    oDone         = 1'b0;
    case (stateReg)
      IDLE: begin
        if (iSTART && (iNUM_FRAMES != '0)) stateNext = START_FRAME;
      end
      START_FRAME: begin
        oWR_ADDR_LOAD = 1'b1;
        stateNext     = STREAM;
      end
      STREAM: begin
        if (pixXfer && frameEnd) stateNext = FRAME_END;
      end
      FRAME_END: begin
        // An abort in this cycle cancels the completion report as well.
        oFrameDone = !iABORT;
        oDone      = !iABORT && lastFrame;
        stateNext  = lastFrame ? IDLE : START_FRAME;
      end
      default: stateNext = IDLE;
    endcase
    if (iABORT) stateNext = IDLE;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      stateReg    <= IDLE;
      loadingReg  <= 1'b0;
      countReg    <= '0;
      frameIdxReg <= '0;
    end else begin
      stateReg   <= stateNext;
      loadingReg <= (stateNext != IDLE);
      if ((stateReg == IDLE) && (stateNext == START_FRAME)) begin
        countReg    <= iNUM_FRAMES;
        frameIdxReg <= '0;
      end else if ((stateReg == FRAME_END) && (stateNext == START_FRAME)) begin
        frameIdxReg <= frameIdxReg + 1'b1;
      end
    end
  end

  // One-cycle write pipeline: a pixel accepted in cycle n is written in n+1,
  // even if an abort arrives in between.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wrEnReg   <= 1'b0;
      wrDataReg <= '0;
    end else begin
      wrEnReg <= pixXfer;
      if (pixXfer) wrDataReg <= packPixel(iPIX_DATA);
    end
  end

endmodule
